// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage with word-addressed data memory and configurable access latency
// Optional MW_misalign port and alignment checking enabled by MEM_ALIGN_CHECK_EN.
module memory_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUout,
    input  logic [4:0]  XM_RD,
    input  logic        XM_lwFlag,
    input  logic        XM_swFlag,
    input  logic [31:0] XM_storeData,
    output logic        stall,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_memData,
    output logic        MW_lwFlag
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        MW_misalign
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                complete;
    logic                mem_op;
    logic                misalign;
    logic [ADDR_W-1:0]   index;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic                unused_addr_bits;

    assign mem_op           = XM_lwFlag | XM_swFlag;
    assign index            = ALUout[ADDR_W+1:2];
    assign unused_addr_bits = ^{ALUout[31:ADDR_W+2], ALUout[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op && (ALUout[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (LAT == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        cnt_next   = LAT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt > 4'd1) begin
                    cnt_next = 4'(cnt - 4'd1);
                end else begin
                    complete   = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall is forced low during reset so upstream never sees a hold on the reset cycle.
    assign stall = !rst && (((state == IDLE) && mem_op && (LAT != 4'd0)) ||
                            ((state == WAIT) && (cnt != 4'd1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            MW_RD      <= 5'd0;
            MW_ALUout  <= 32'd0;
            MW_memData <= 32'd0;
            MW_lwFlag  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            MW_misalign <= 1'b0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
`ifdef MEM_ALIGN_CHECK_EN
            MW_misalign <= complete && misalign;
`endif
            if (!mem_op) begin
                MW_RD      <= XM_RD;
                MW_ALUout  <= ALUout;
                MW_memData <= 32'd0;
                MW_lwFlag  <= 1'b0;
            end else if (complete && !misalign && XM_lwFlag) begin
                MW_RD      <= XM_RD;
                MW_ALUout  <= ALUout;
                MW_memData <= mem[index];
                MW_lwFlag  <= 1'b1;
            end else if (complete) begin
                // Store or rejected misaligned access: no writeback.
                MW_RD      <= 5'd0;
                MW_ALUout  <= ALUout;
                MW_memData <= 32'd0;
                MW_lwFlag  <= 1'b0;
            end else begin
                MW_RD      <= 5'd0;
                MW_ALUout  <= 32'd0;
                MW_memData <= 32'd0;
                MW_lwFlag  <= 1'b0;
            end
        end
    end

    // Array has no reset so stored words survive rst.
    always_ff @(posedge clk) begin
        if (!rst && complete && XM_swFlag && !XM_lwFlag && !misalign) begin
            mem[index] <= XM_storeData;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed table-driven bench for memory_stage at MEM_LAT 0, 2 and 3
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        lw = 1'b0;
    logic        sw = 1'b0;
    logic [31:0] sd = 32'd0;

    logic        stall0, stall2, stall3;
    logic [4:0]  rd0, rd2, rd3;
    logic [31:0] alu0, alu2, alu3;
    logic [31:0] data0, data2, data3;
    logic        lwf0, lwf2, lwf3;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mis0, mis2, mis3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(8), .MEM_LAT(0)) u0 (
        .clk(clk), .rst(rst), .ALUout(alu), .XM_RD(rd), .XM_lwFlag(lw), .XM_swFlag(sw),
        .XM_storeData(sd), .stall(stall0), .MW_RD(rd0), .MW_ALUout(alu0),
        .MW_memData(data0), .MW_lwFlag(lwf0)
`ifdef MEM_ALIGN_CHECK_EN
        , .MW_misalign(mis0)
`endif
    );

    memory_stage #(.ADDR_W(8), .MEM_LAT(2)) u2 (
        .clk(clk), .rst(rst), .ALUout(alu), .XM_RD(rd), .XM_lwFlag(lw), .XM_swFlag(sw),
        .XM_storeData(sd), .stall(stall2), .MW_RD(rd2), .MW_ALUout(alu2),
        .MW_memData(data2), .MW_lwFlag(lwf2)
`ifdef MEM_ALIGN_CHECK_EN
        , .MW_misalign(mis2)
`endif
    );

    memory_stage #(.ADDR_W(8), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst), .ALUout(alu), .XM_RD(rd), .XM_lwFlag(lw), .XM_swFlag(sw),
        .XM_storeData(sd), .stall(stall3), .MW_RD(rd3), .MW_ALUout(alu3),
        .MW_memData(data3), .MW_lwFlag(lwf3)
`ifdef MEM_ALIGN_CHECK_EN
        , .MW_misalign(mis3)
`endif
    );

    typedef struct {
        string       name;
        logic        lw;
        logic        sw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic [31:0] e_data;
        logic        e_lw;
        bit          chk_alu;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic s, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d);
        lw  = l;
        sw  = s;
        rd  = r;
        alu = a;
        sd  = d;
    endtask

    initial begin
        vecs[0] = '{"alu_op",      0, 0, 5'd3,  32'h1234,     32'h0,        5'd3,  32'h1234,     32'h0,        1'b0, 1};
        vecs[1] = '{"sw_10",       0, 1, 5'd9,  32'h10,       32'hDEADBEEF, 5'd0,  32'h0,        32'h0,        1'b0, 0};
        vecs[2] = '{"lw_10",       1, 0, 5'd5,  32'h10,       32'h0,        5'd5,  32'h10,       32'hDEADBEEF, 1'b1, 1};
        vecs[3] = '{"sw_000",      0, 1, 5'd1,  32'h000,      32'h11,       5'd0,  32'h0,        32'h0,        1'b0, 0};
        vecs[4] = '{"lw_400_wrap", 1, 0, 5'd6,  32'h400,      32'h0,        5'd6,  32'h400,      32'h11,       1'b1, 1};
        vecs[5] = '{"lw_sw_both",  1, 1, 5'd8,  32'h10,       32'h55,       5'd8,  32'h10,       32'hDEADBEEF, 1'b1, 1};
        vecs[6] = '{"lw_10_again", 1, 0, 5'd8,  32'h10,       32'h0,        5'd8,  32'h10,       32'hDEADBEEF, 1'b1, 1};
        vecs[7] = '{"alu_op_max",  0, 0, 5'd31, 32'hFFFFFFFF, 32'h0,        5'd31, 32'hFFFFFFFF, 32'h0,        1'b0, 1};

        // Reset state
        step();
        step();
        chk("rst_rd0",    {27'd0, rd0}, 32'd0);
        chk("rst_alu0",   alu0, 32'd0);
        chk("rst_data0",  data0, 32'd0);
        chk("rst_lw0",    {31'd0, lwf0}, 32'd0);
        chk("rst_stall2", {31'd0, stall2}, 32'd0);
        chk("rst_rd3",    {27'd0, rd3}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_mis0",   {31'd0, mis0}, 32'd0);
`endif
        rst = 1'b0;

        // Single-cycle table on the MEM_LAT=0 instance
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].lw, vecs[i].sw, vecs[i].rd, vecs[i].alu, vecs[i].sd);
            #1;
            chk({vecs[i].name, "_stall"}, {31'd0, stall0}, 32'd0);
            step();
            chk({vecs[i].name, "_rd"}, {27'd0, rd0}, {27'd0, vecs[i].e_rd});
            chk({vecs[i].name, "_data"}, data0, vecs[i].e_data);
            chk({vecs[i].name, "_lw"}, {31'd0, lwf0}, {31'd0, vecs[i].e_lw});
            if (vecs[i].chk_alu) chk({vecs[i].name, "_alu"}, alu0, vecs[i].e_alu);
        end

`ifdef MEM_ALIGN_CHECK_EN
        drive(0, 1, 5'd4, 32'h13, 32'h77);
        step();
        chk("mis_sw_flag", {31'd0, mis0}, 32'd1);
        chk("mis_sw_rd",   {27'd0, rd0}, 32'd0);
        chk("mis_sw_lw",   {31'd0, lwf0}, 32'd0);
        drive(0, 0, 5'd2, 32'h5, 32'h0);
        step();
        chk("mis_clear",   {31'd0, mis0}, 32'd0);
        drive(1, 0, 5'd5, 32'h10, 32'h0);
        step();
        chk("mis_prior_data", data0, 32'hDEADBEEF);
        drive(1, 0, 5'd5, 32'h12, 32'h0);
        step();
        chk("mis_lw_data", data0, 32'h0);
        chk("mis_lw_flag", {31'd0, mis0}, 32'd1);
        chk("mis_lw_lw",   {31'd0, lwf0}, 32'd0);
`else
        drive(1, 0, 5'd5, 32'h12, 32'h0);
        step();
        chk("unaligned_lw_data", data0, 32'hDEADBEEF);
        chk("unaligned_lw_rd",   {27'd0, rd0}, 32'd5);
`endif

        // Clear the multi-cycle instances before their own sequences
        drive(0, 0, 5'd0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // MEM_LAT=2: store then load, stall for two cycles each
        drive(0, 1, 5'd0, 32'h20, 32'hCAFEF00D);
        #1;
        chk("l2_sw_stall_c1", {31'd0, stall2}, 32'd1);
        step();
        chk("l2_sw_stall_c2", {31'd0, stall2}, 32'd1);
        step();
        chk("l2_sw_stall_c3", {31'd0, stall2}, 32'd0);
        step();
        drive(1, 0, 5'd7, 32'h20, 32'h0);
        #1;
        chk("l2_lw_stall_c1", {31'd0, stall2}, 32'd1);
        step();
        chk("l2_lw_bubble1_rd", {27'd0, rd2}, 32'd0);
        chk("l2_lw_stall_c2", {31'd0, stall2}, 32'd1);
        step();
        chk("l2_lw_bubble2_rd", {27'd0, rd2}, 32'd0);
        chk("l2_lw_bubble2_lw", {31'd0, lwf2}, 32'd0);
        chk("l2_lw_stall_c3", {31'd0, stall2}, 32'd0);
        step();
        chk("l2_lw_rd",   {27'd0, rd2}, 32'd7);
        chk("l2_lw_data", data2, 32'hCAFEF00D);
        chk("l2_lw_flag", {31'd0, lwf2}, 32'd1);
        drive(0, 0, 5'd3, 32'h1234, 32'h0);
        #1;
        chk("l2_alu_nostall", {31'd0, stall2}, 32'd0);
        step();
        chk("l2_alu_rd",  {27'd0, rd2}, 32'd3);
        chk("l2_alu_val", alu2, 32'h1234);

        // MEM_LAT=3: establish a word, then reset in the middle of a store
        drive(0, 0, 5'd0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1, 5'd0, 32'h40, 32'h12345678);
        for (int i = 0; i < 4; i++) step();
        drive(1, 0, 5'd2, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("l3_lw_data", data3, 32'h12345678);
        chk("l3_lw_rd",   {27'd0, rd3}, 32'd2);
        drive(0, 1, 5'd0, 32'h40, 32'h00000BAD);
        step();
        step();
        chk("l3_wait_stall", {31'd0, stall3}, 32'd1);
        rst = 1'b1;
        #1;
        chk("l3_rst_stall_comb", {31'd0, stall3}, 32'd0);
        step();
        step();
        chk("l3_rst_rd",    {27'd0, rd3}, 32'd0);
        chk("l3_rst_alu",   alu3, 32'd0);
        chk("l3_rst_data",  data3, 32'd0);
        chk("l3_rst_lw",    {31'd0, lwf3}, 32'd0);
        chk("l3_rst_stall", {31'd0, stall3}, 32'd0);
        rst = 1'b0;
        drive(0, 0, 5'd0, 32'h0, 32'h0);
        step();
        drive(1, 0, 5'd2, 32'h40, 32'h0);
        #1;
        chk("l3_post_rst_stall", {31'd0, stall3}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("l3_intact_data", data3, 32'h12345678);
        chk("l3_intact_lw",   {31'd0, lwf3}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage for the 5-stage MIPS core. It consumes the EX/MEM pipeline register (ALU result, destination register, load/store flags plus store data) and performs load/store against an internal word-addressed data memory with configurable access latency. It drives the MEM/WB pipeline register and a stall back to the upstream stages.

## Interface
- ADDR_W, 8: word-index width; memory holds 2^ADDR_W 32-bit words.
- MEM_LAT, 0: extra wait cycles per load/store (0..15); 0 means single-cycle access.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- ALUout  in  32  ALU result; byte address for lw/sw, writeback value otherwise.
- XM_RD  in  5  destination register.
- XM_lwFlag  in  1  load in this slot.
- XM_swFlag  in  1  store in this slot.
- XM_storeData  in  32  store data (rt value).
- stall  out  1  combinational; upstream holds all XM_* inputs and EX state while high.
- MW_RD  out  5  registered destination register.
- MW_ALUout  out  32  registered ALU result.
- MW_memData  out  32  registered load data.
- MW_lwFlag  out  1  registered; WB selects MW_memData when 1, MW_ALUout when 0.
- MW_misalign  out  1  registered; present only with MEM_ALIGN_CHECK_EN.

## Operation
- Word index = ALUout[ADDR_W+1:2]; higher address bits ignored (address wraps modulo memory size).
- Both flags high: treated as a load; store suppressed.
- Non-memory slot (both flags 0): always single-cycle; MW_RD<=XM_RD, MW_ALUout<=ALUout, MW_lwFlag<=0, MW_memData<=0.
- FSM states IDLE, WAIT; 4-bit counter cnt.
- IDLE, memory op, MEM_LAT==0: complete at this edge.
- IDLE, memory op, MEM_LAT>0: cnt<=MEM_LAT, go WAIT; MW_* loaded with a bubble (MW_RD=0, MW_lwFlag=0, MW_ALUout=0, MW_memData=0).
- WAIT, cnt>1: cnt<=cnt-1; MW_* bubble.
- WAIT, cnt==1: complete at this edge; go IDLE.
- Complete, load: MW_memData<=mem[index], MW_lwFlag<=1, MW_RD<=XM_RD, MW_ALUout<=ALUout.
- Complete, store: mem[index]<=XM_storeData; MW_RD<=0, MW_lwFlag<=0 (no writeback).
- Load after store to the same word in the next slot returns the new data.
- stall = (IDLE & (XM_lwFlag|XM_swFlag) & MEM_LAT!=0) | (WAIT & cnt!=1).

## Timing
- Reset values: MW_RD=0, MW_ALUout=0, MW_memData=0, MW_lwFlag=0, MW_misalign=0, state IDLE, cnt=0; stall=0 while rst high.
- Memory array contents not affected by rst.
- ALU op latency: 1 cycle (inputs at edge N visible on MW_* after edge N).
- Load/store occupancy: MEM_LAT+1 cycles; stall high for the first MEM_LAT of them.
- rst mid-WAIT: state IDLE, pending store discarded (memory unchanged), MW_* to reset values.
- Inputs are sampled only at the completing edge; changes during stall are a protocol violation and are not checked.

## Configuration
- MEM_ALIGN_CHECK_EN defined: MW_misalign port exists; a lw/sw with ALUout[1:0]!=0 completes with the normal timing but the store is suppressed, MW_memData=0, MW_lwFlag=0, MW_RD=0, MW_misalign=1 for one cycle.
- Undefined: no port; ALUout[1:0] ignored; misaligned accesses behave as aligned.

## Test plan
- Reset: hold rst 2 cycles mid-WAIT (MEM_LAT=3) -> all MW_*=0, stall=0, previously stored words intact.
- MEM_LAT=0: sw 0xDEADBEEF to 0x10, then lw 0x10 RD=5 -> next cycle MW_memData=0xDEADBEEF, MW_lwFlag=1, MW_RD=5, stall never high.
- MEM_LAT=2: lw RD=7 -> stall high 2 cycles, MW_RD=0 on those cycles, data on MW_* after 3rd edge.
- ALU op ALUout=0x1234, RD=3 -> MW_ALUout=0x1234, MW_RD=3, MW_lwFlag=0 after 1 edge.
- ADDR_W=8: sw 0x11 to 0x000 then lw 0x400 -> returns 0x11 (wrap); lw+sw both high -> load, memory unchanged.
- MEM_ALIGN_CHECK_EN: sw to 0x13 -> MW_misalign=1 one cycle, lw 0x10 returns prior value.
